// File: rtl/vram_port_arbiter.sv
// Char_Ram port-A arbiter: single-cycle CPU character writes take priority over
// a background whole-screen fill engine; one registered port-A write per cycle.
module vram_port_arbiter #(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic        Clk_CPU,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr_x_y,
  input  logic [10:0] cpu_data,
  input  logic        fill_start,
  input  logic        fill_abort,
  input  logic [10:0] fill_data,
  output logic        vram_we,
  output logic [12:0] vram_addr,
  output logic [10:0] vram_data,
  output logic        busy,
  output logic        fill_done,
  output logic        range_err
);

  localparam int          CELLS     = COLS * ROWS;
  localparam logic [12:0] LAST_ADDR = 13'(CELLS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t      state_reg, state_next;
  logic [12:0] count_reg, count_next;
  logic [10:0] word_reg, word_next;
  logic        we_next, done_next, err_next;
  logic [12:0] addr_next;
  logic [10:0] data_next;

  logic [7:0]  cpu_x;
  logic [5:0]  cpu_y;
  logic        cpu_in_range;
  logic [12:0] cpu_lin;

  assign cpu_x        = cpu_addr_x_y[7:0];
  assign cpu_y        = cpu_addr_x_y[13:8];
  assign cpu_in_range = (int'(cpu_x) < COLS) && (int'(cpu_y) < ROWS);
  // Full-width multiply, then keep the low 13 bits of the linear address.
  assign cpu_lin      = 13'(int'(cpu_y) * COLS + int'(cpu_x));

  assign busy = (state_reg == FILL);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    word_next  = word_reg;
    we_next    = 1'b0;
    addr_next  = vram_addr;
    data_next  = vram_data;
    done_next  = 1'b0;
    err_next   = range_err;

    if (cpu_we) begin
      if (cpu_in_range) begin
        we_next   = 1'b1;
        addr_next = cpu_lin;
        data_next = cpu_data;
      end else begin
        err_next = 1'b1;
      end
    end

    case (state_reg)
      IDLE: begin
        if (fill_start) begin
          word_next  = fill_data;
          count_next = '0;
          state_next = FILL;
        end
      end
      FILL: begin
        // Abort beats both a concurrent start and the fill slot of this cycle.
        if (fill_abort) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (!cpu_we) begin
          we_next   = 1'b1;
          addr_next = count_reg;
          data_next = word_reg;
          if (count_reg == LAST_ADDR) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            count_next = count_reg + 13'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CPU or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      word_reg  <= '0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
      fill_done <= 1'b0;
      range_err <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      word_reg  <= word_next;
      vram_we   <= we_next;
      vram_addr <= addr_next;
      vram_data <= data_next;
      fill_done <= done_next;
      range_err <= err_next;
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter: stimulus queues expected port-A events,
// a negedge monitor pops and compares every write or fill_done pulse.
module tb_vram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_we;
  logic [13:0] cpu_addr_x_y;
  logic [10:0] cpu_data;
  logic        fill_start;
  logic        fill_abort;
  logic [10:0] fill_data;
  logic        vram_we;
  logic [12:0] vram_addr;
  logic [10:0] vram_data;
  logic        busy;
  logic        fill_done;
  logic        range_err;

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [10:0] data;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   busy_cycles = 0;
  int   busy_base;

  vram_port_arbiter #(.COLS(80), .ROWS(60)) dut (
    .Clk_CPU     (clk),
    .rst         (rst),
    .cpu_we      (cpu_we),
    .cpu_addr_x_y(cpu_addr_x_y),
    .cpu_data    (cpu_data),
    .fill_start  (fill_start),
    .fill_abort  (fill_abort),
    .fill_data   (fill_data),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .vram_data   (vram_data),
    .busy        (busy),
    .fill_done   (fill_done),
    .range_err   (range_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s got=%0h need=%0h", name, got, need);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input int addr, input int data, input logic done);
    exp_t e;
    e.we = we; e.addr = 13'(addr); e.data = 11'(data); e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic push_fill(input int first, input int last, input int data, input logic done_last);
    for (int a = first; a <= last; a++)
      push(1'b1, a, data, done_last && (a == last));
  endtask

  task automatic cpu_write(input int x, input int y, input int data);
    cpu_we       = 1'b1;
    cpu_addr_x_y = {6'(y), 8'(x)};
    cpu_data     = 11'(data);
  endtask

  task automatic wait_idle(input int max_cycles, input int need_busy, input string name);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(busy), 32'd0);
    check({name, "_busy_cycles"}, 32'(busy_cycles - busy_base), 32'(need_busy));
  endtask

  // Monitor: every write or fill_done pulse must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (vram_we || fill_done) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event got we=%0b addr=%0d data=%h done=%0b need none",
                   vram_we, vram_addr, vram_data, fill_done);
        end else begin
          e = exp_q.pop_front();
          if (vram_we !== e.we || fill_done !== e.done ||
              (e.we && (vram_addr !== e.addr || vram_data !== e.data))) begin
            bad++;
            $display("FAIL port_event got we=%0b addr=%0d data=%h done=%0b need we=%0b addr=%0d data=%h done=%0b",
                     vram_we, vram_addr, vram_data, fill_done, e.we, e.addr, e.data, e.done);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; cpu_we = 1'b0; cpu_addr_x_y = '0; cpu_data = '0;
    fill_start = 1'b0; fill_abort = 1'b0; fill_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {26'd0, vram_we, busy, fill_done, range_err, 2'd0}, 32'd0);
    check("reset_addr_data", {8'd0, vram_addr, vram_data}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single in-range CPU write: (5,2) -> 165.
    push(1'b1, 165, 11'h041, 1'b0);
    cpu_write(5, 2, 11'h041);
    tick();
    cpu_we = 1'b0;
    tick();
    check("range_err_clear", 32'(range_err), 32'd0);

    // Out-of-range column, then row: dropped and sticky error.
    cpu_write(80, 0, 11'h007);
    tick();
    cpu_we = 1'b0;
    tick();
    check("range_err_x", 32'(range_err), 32'd1);
    cpu_write(0, 60, 11'h008);
    tick();
    push(1'b1, 4720, 11'h155, 1'b0);
    cpu_write(0, 59, 11'h155);
    tick();
    cpu_we = 1'b0;
    tick(); tick();
    check("range_err_sticky", 32'(range_err), 32'd1);
    check("hold_addr", 32'(vram_addr), 32'd4720);
    check("hold_data", 32'(vram_data), 32'h155);

    // Full fill; abort alongside start in IDLE is ignored, a start inside FILL too.
    push_fill(0, 4799, 11'h020, 1'b1);
    busy_base = busy_cycles;
    fill_start = 1'b1; fill_abort = 1'b1; fill_data = 11'h020;
    tick();
    fill_start = 1'b0; fill_abort = 1'b0;
    repeat (5) tick();
    fill_start = 1'b1; fill_data = 11'h7ff;
    tick();
    fill_start = 1'b0;
    wait_idle(6000, 4800, "fill_plain");
    tick();
    check("done_low_after", 32'(fill_done), 32'd0);

    // Three CPU writes at counter 10 stall the fill.
    push_fill(0, 9, 11'h0aa, 1'b0);
    push(1'b1, 1, 11'h301, 1'b0);
    push(1'b1, 2, 11'h302, 1'b0);
    push(1'b1, 3, 11'h303, 1'b0);
    push_fill(10, 4799, 11'h0aa, 1'b1);
    busy_base = busy_cycles;
    fill_start = 1'b1; fill_data = 11'h0aa;
    tick();
    fill_start = 1'b0;
    repeat (10) tick();
    for (int i = 1; i <= 3; i++) begin
      cpu_write(i, 0, 11'h300 + 11'(i));
      tick();
    end
    cpu_we = 1'b0;
    wait_idle(6000, 4803, "fill_stall");

    // CPU write with start in IDLE, then abort (with start) at counter 100.
    push(1'b1, 87, 11'h111, 1'b0);
    push_fill(0, 99, 11'h033, 1'b0);
    push(1'b0, 0, 0, 1'b1);
    busy_base = busy_cycles;
    cpu_write(7, 1, 11'h111);
    fill_start = 1'b1; fill_data = 11'h033;
    tick();
    cpu_we = 1'b0; fill_start = 1'b0;
    repeat (100) tick();
    fill_abort = 1'b1; fill_start = 1'b1; fill_data = 11'h123;
    tick();
    fill_abort = 1'b0; fill_start = 1'b0;
    check("abort_busy_low", 32'(busy), 32'd0);
    check("abort_busy_cycles", 32'(busy_cycles - busy_base), 32'd101);

    // Restart next cycle, then asynchronous reset at counter 2000.
    push_fill(0, 1999, 11'h0f0, 1'b0);
    fill_start = 1'b1; fill_data = 11'h0f0;
    tick();
    fill_start = 1'b0;
    check("restart_accepted", 32'(busy), 32'd1);
    repeat (2000) tick();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_flags", {28'd0, vram_we, busy, fill_done, range_err}, 32'd0);
    check("async_rst_addr_data", {8'd0, vram_addr, vram_data}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_no_pending", 32'(exp_q.size()), 32'd0);

    // Next fill after reset begins at address 0.
    push_fill(0, 4799, 11'h055, 1'b1);
    busy_base = busy_cycles;
    fill_start = 1'b1; fill_data = 11'h055;
    tick();
    fill_start = 1'b0;
    wait_idle(6000, 4800, "fill_after_rst");
    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning characters per text row.
REQ-002 SHALL have parameter ROWS, default 60, meaning text rows; COLS*ROWS SHALL be at most 8192.
REQ-003 SHALL have port Clk_CPU  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cpu_we  input  1  CPU character write strobe, one cycle per write.
REQ-006 SHALL have port cpu_addr_x_y  input  14  CPU cell address: [13:8] row y, [7:0] column x.
REQ-007 SHALL have port cpu_data  input  11  CPU character/attribute word.
REQ-008 SHALL have port fill_start  input  1  pulse; starts a whole-screen fill.
REQ-009 SHALL have port fill_abort  input  1  pulse; terminates a fill in progress.
REQ-010 SHALL have port fill_data  input  11  fill word, sampled on an accepted fill_start.
REQ-011 SHALL have port vram_we  output  1  Char_Ram port-A write enable.
REQ-012 SHALL have port vram_addr  output  13  Char_Ram port-A linear address.
REQ-013 SHALL have port vram_data  output  11  Char_Ram port-A write data.
REQ-014 SHALL have port busy  output  1  high while a fill is in progress.
REQ-015 SHALL have port fill_done  output  1  one-cycle pulse when a fill completes or aborts.
REQ-016 SHALL have port range_err  output  1  sticky flag: a CPU write was dropped as out of range.

Function
REQ-017 SHALL implement a two-state FSM: IDLE, FILL.
REQ-018 In IDLE, fill_start SHALL latch fill_data, clear the fill counter to 0, and enter FILL next cycle.
REQ-019 fill_start while in FILL SHALL be ignored; the latched word and counter SHALL be unchanged.
REQ-020 The output registers (vram_we/addr/data) SHALL update one cycle after the selected request: one port-A write per cycle maximum.
REQ-021 A CPU write SHALL have priority: if cpu_we is high, that cycle's slot SHALL go to the CPU, and the fill counter SHALL hold.
REQ-022 The CPU linear address SHALL be y*COLS + x, computed at full width and truncated to 13 bits.
REQ-023 A CPU write with x >= COLS or y >= ROWS SHALL not be issued: vram_we stays low for that slot, and range_err sets to 1.
REQ-024 range_err SHALL clear only on reset.
REQ-025 In FILL with cpu_we low, the slot SHALL write the latched fill word to the address equal to the counter, then increment the counter.
REQ-026 After the slot for address COLS*ROWS-1 is issued, the FSM SHALL return to IDLE and pulse fill_done in the same cycle as that last vram_we.
REQ-027 fill_abort in FILL SHALL return the FSM to IDLE next cycle and pulse fill_done once; no further fill writes are issued; a fill write already registered that cycle still completes.
REQ-028 fill_abort in IDLE SHALL be ignored.
REQ-029 fill_abort and fill_start in the same IDLE cycle: the start SHALL win.
REQ-030 fill_abort and fill_start in the same FILL cycle: the abort SHALL win.
REQ-031 busy SHALL be high exactly while the FSM is in FILL.
REQ-032 A CPU write during FILL to an address already passed by the counter SHALL persist.
REQ-033 A CPU write during FILL to an address not yet reached SHALL be overwritten by the fill; this is the defined behaviour.
REQ-034 cpu_we coincident with fill_start in IDLE: the CPU write SHALL be issued, and FILL SHALL begin next cycle at counter 0.
REQ-035 When no write is issued, vram_addr and vram_data SHALL hold their last values.

Reset
REQ-036 On rst, the FSM SHALL go to IDLE and the counter SHALL be 0.
REQ-037 On rst, all of vram_we, vram_addr, vram_data, busy, fill_done, and range_err SHALL be 0.
REQ-038 On rst, the latched fill word SHALL be 0.
REQ-039 rst asserted mid-fill SHALL abandon the fill without a fill_done pulse.

Verification
REQ-040 CPU write x=5, y=2, data=11'h041 in IDLE -> next cycle vram_we=1, vram_addr=165, vram_data=11'h041.
REQ-041 fill_start with fill_data=11'h020 and no CPU traffic -> 4800 consecutive writes to addresses 0..4799. busy high for 4800 cycles. fill_done coincides with the write to 4799.
REQ-042 cpu_we held high for 3 cycles at fill counter 10 -> 3 CPU writes are issued, the counter holds at 10, then the fill resumes at 10; total fill duration is 4803 cycles.
REQ-043 CPU write x=80, y=0 -> no vram_we and range_err=1. A subsequent valid write still issues, and range_err stays 1.
REQ-044 fill_abort at counter 100 -> last fill write at address ≤100, fill_done pulses once, busy low. A new fill_start is accepted next cycle.
REQ-045 rst pulsed at counter 2000 -> all outputs 0 immediately (asynchronous). No fill_done pulse. The next fill starts at address 0.
